// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size/response encodings and master FSM state type
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_DONE
    } state_t;

    // Size 3 is never legal; half needs even address, word needs 4-byte alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b1;
        if (size == SZ_B)      bad = 1'b0;
        else if (size == SZ_H) bad = addr_lo[0];
        else if (size == SZ_W) bad = (addr_lo != 2'b00);
        return bad;
    endfunction

endpackage

// File: rtl/lane_align.sv
// rtl/lane_align.sv - byte-lane placement for stores and lane extraction/extension for loads
import mem_pkg::*;

module lane_align (
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [31:0] wdata_out,
    output logic [3:0]  wstrb_out,
    output logic [31:0] rdata_out
);

    logic [31:0] rshift;

    // Shift store data up to its lane, pick strobes, and pull the load lane down to bit 0.
    always_comb begin
        wdata_out = wdata_in << {addr_lo, 3'b000};
        rshift    = rdata_in >> {addr_lo, 3'b000};
        if (size == SZ_B) begin
            wstrb_out = 4'b0001 << addr_lo;
            rdata_out = unsigned_ld ? {24'h000000, rshift[7:0]}
                                    : {{24{rshift[7]}}, rshift[7:0]};
        end else if (size == SZ_H) begin
            wstrb_out = 4'b0011 << addr_lo;
            rdata_out = unsigned_ld ? {16'h0000, rshift[15:0]}
                                    : {{16{rshift[15]}}, rshift[15:0]};
        end else begin
            wstrb_out = 4'b1111;
            rdata_out = rshift;
        end
    end

endmodule

// File: rtl/core_axi_master.sv
// rtl/core_axi_master.sv - single-outstanding core load/store to AXI4-Lite master bridge
import mem_pkg::*;

module core_axi_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   axi_araddr,
    output logic                axi_arvalid,
    input  logic                axi_arready,
    input  logic [DATA_W-1:0]   axi_rdata,
    input  logic [1:0]          axi_rresp,
    input  logic                axi_rvalid,
    output logic                axi_rready,
    output logic [ADDR_W-1:0]   axi_awaddr,
    output logic                axi_awvalid,
    input  logic                axi_awready,
    output logic [DATA_W-1:0]   axi_wdata,
    output logic [DATA_W/8-1:0] axi_wstrb,
    output logic                axi_wvalid,
    input  logic                axi_wready,
    input  logic [1:0]          axi_bresp,
    input  logic                axi_bvalid,
    output logic                axi_bready
);

    state_t      state;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_addr_lo;
    logic        aw_done;
    logic        w_done;

    logic [1:0]  lane_size;
    logic        lane_unsigned;
    logic [1:0]  lane_addr_lo;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic [31:0] lane_rdata;
    logic        aw_fire;
    logic        w_fire;

    // In IDLE the lane logic sees the incoming request (store lanes); afterwards the held fields (load extraction).
    always_comb begin
        lane_size     = (state == ST_IDLE) ? req_size      : r_size;
        lane_unsigned = (state == ST_IDLE) ? req_unsigned  : r_unsigned;
        lane_addr_lo  = (state == ST_IDLE) ? req_addr[1:0] : r_addr_lo;
        aw_fire       = axi_awvalid & axi_awready;
        w_fire        = axi_wvalid & axi_wready;
    end

    lane_align u_lane_align (
        .size        (lane_size),
        .unsigned_ld (lane_unsigned),
        .addr_lo     (lane_addr_lo),
        .wdata_in    (req_wdata),
        .rdata_in    (axi_rdata),
        .wdata_out   (lane_wdata),
        .wstrb_out   (lane_wstrb),
        .rdata_out   (lane_rdata)
    );

    // Transaction FSM; every bus and response output is a register updated on state transitions.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            r_size      <= SZ_B;
            r_unsigned  <= 1'b0;
            r_addr_lo   <= 2'b00;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            axi_araddr  <= '0;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
            axi_awaddr  <= '0;
            axi_awvalid <= 1'b0;
            axi_wdata   <= '0;
            axi_wstrb   <= '0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr_lo  <= req_addr[1:0];
                        req_ready  <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            state      <= ST_DONE;
                        end else if (req_we) begin
                            axi_awaddr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            axi_wdata   <= lane_wdata;
                            axi_wstrb   <= lane_wstrb;
                            axi_awvalid <= 1'b1;
                            axi_wvalid  <= 1'b1;
                            aw_done     <= 1'b0;
                            w_done      <= 1'b0;
                            state       <= ST_WR_REQ;
                        end else begin
                            axi_araddr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            axi_arvalid <= 1'b1;
                            state       <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        axi_rready  <= 1'b1;
                        state       <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (axi_rvalid) begin
                        axi_rready <= 1'b0;
                        resp_err   <= (axi_rresp != RESP_OKAY);
                        resp_rdata <= (axi_rresp == RESP_OKAY) ? lane_rdata : '0;
                        resp_valid <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_WR_REQ: begin
                    if (aw_fire) begin
                        axi_awvalid <= 1'b0;
                        aw_done     <= 1'b1;
                    end
                    if (w_fire) begin
                        axi_wvalid <= 1'b0;
                        w_done     <= 1'b1;
                    end
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        axi_bready <= 1'b1;
                        state      <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (axi_bvalid) begin
                        axi_bready <= 1'b0;
                        resp_err   <= (axi_bresp != RESP_OKAY);
                        resp_valid <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_axi_master.sv
// tb/tb_core_axi_master.sv - directed scoreboard bench for core_axi_master with a delay-configurable AXI slave
`timescale 1ns/1ps

module tb_core_axi_master;

    logic        clk;
    logic        rstn;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic [1:0]  axi_rresp, axi_bresp;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
    logic [3:0]  axi_wstrb;

    int n_vec = 0;
    int n_err = 0;

    int ar_dly = 0, aw_dly = 0, w_dly = 0, r_dly = 0, b_dly = 0;
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = 2'b00;
    logic [1:0]  s_bresp = 2'b00;

    int wv_cyc = 0, awv_cyc = 0, arv_cyc = 0, b_hs = 0, resp_cnt = 0;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    core_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .axi_araddr   (axi_araddr),
        .axi_arvalid  (axi_arvalid),
        .axi_arready  (axi_arready),
        .axi_rdata    (axi_rdata),
        .axi_rresp    (axi_rresp),
        .axi_rvalid   (axi_rvalid),
        .axi_rready   (axi_rready),
        .axi_awaddr   (axi_awaddr),
        .axi_awvalid  (axi_awvalid),
        .axi_awready  (axi_awready),
        .axi_wdata    (axi_wdata),
        .axi_wstrb    (axi_wstrb),
        .axi_wvalid   (axi_wvalid),
        .axi_wready   (axi_wready),
        .axi_bresp    (axi_bresp),
        .axi_bvalid   (axi_bvalid),
        .axi_bready   (axi_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (axi_wvalid)               wv_cyc   <= wv_cyc + 1;
        if (axi_awvalid)              awv_cyc  <= awv_cyc + 1;
        if (axi_arvalid)              arv_cyc  <= arv_cyc + 1;
        if (axi_bvalid && axi_bready) b_hs     <= b_hs + 1;
        if (resp_valid)               resp_cnt <= resp_cnt + 1;
    end

    initial begin
        axi_arready = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0;
        axi_rvalid  = 1'b0; axi_bvalid  = 1'b0;
        axi_rdata   = '0;   axi_rresp   = 2'b00; axi_bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                axi_arready = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0;
                axi_rvalid  = 1'b0; axi_bvalid  = 1'b0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
            end else begin
                axi_arready = axi_arvalid && (ar_cnt >= ar_dly);
                ar_cnt      = axi_arvalid ? ar_cnt + 1 : 0;
                axi_awready = axi_awvalid && (aw_cnt >= aw_dly);
                aw_cnt      = axi_awvalid ? aw_cnt + 1 : 0;
                axi_wready  = axi_wvalid && (w_cnt >= w_dly);
                w_cnt       = axi_wvalid ? w_cnt + 1 : 0;
                axi_rvalid  = axi_rready && (r_cnt >= r_dly);
                r_cnt       = axi_rready ? r_cnt + 1 : 0;
                axi_rdata   = s_rdata;
                axi_rresp   = s_rresp;
                axi_bvalid  = axi_bready && (b_cnt >= b_dly);
                b_cnt       = axi_bready ? b_cnt + 1 : 0;
                axi_bresp   = s_bresp;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic mis,
                          input logic [31:0] exp_baddr, input logic [31:0] exp_bwdata,
                          input logic [3:0] exp_strb, input logic [31:0] exp_rd,
                          input logic exp_err, input int exp_lat);
        int lat;
        exp_t e;
        exp_q.push_back('{rd: exp_rd, err: exp_err});
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $error("FAIL req_ready_idle: %0h", req_ready); end
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        if (!mis) begin
            if (we) begin
                n_vec++; if (axi_awvalid !== 1'b1) begin n_err++; $error("FAIL awvalid: %0h", axi_awvalid); end
                n_vec++; if (axi_wvalid !== 1'b1) begin n_err++; $error("FAIL wvalid: %0h", axi_wvalid); end
                n_vec++; if (axi_awaddr !== exp_baddr) begin n_err++; $error("FAIL awaddr: %0h exp %0h", axi_awaddr, exp_baddr); end
                n_vec++; if (axi_wdata !== exp_bwdata) begin n_err++; $error("FAIL wdata: %0h exp %0h", axi_wdata, exp_bwdata); end
                n_vec++; if (axi_wstrb !== exp_strb) begin n_err++; $error("FAIL wstrb: %0h exp %0h", axi_wstrb, exp_strb); end
            end else begin
                n_vec++; if (axi_arvalid !== 1'b1) begin n_err++; $error("FAIL arvalid: %0h", axi_arvalid); end
                n_vec++; if (axi_araddr !== exp_baddr) begin n_err++; $error("FAIL araddr: %0h exp %0h", axi_araddr, exp_baddr); end
            end
        end
        while (!resp_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        n_vec++; if (resp_valid !== 1'b1) begin n_err++; $error("FAIL resp_valid: %0h", resp_valid); end
        e = exp_q.pop_front();
        n_vec++; if (resp_rdata !== e.rd) begin n_err++; $error("FAIL resp_rdata: %0h exp %0h", resp_rdata, e.rd); end
        n_vec++; if (resp_err !== e.err) begin n_err++; $error("FAIL resp_err: %0h exp %0h", resp_err, e.err); end
        if (exp_lat != 0) begin
            n_vec++; if (lat !== exp_lat) begin n_err++; $error("FAIL latency: %0d exp %0d", lat, exp_lat); end
        end
        @(negedge clk);
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $error("FAIL resp_pulse_end: %0h", resp_valid); end
    endtask

    initial begin
        int s_ar, s_aw, s_w, s_b, s_resp, k;
        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $error("FAIL rst_req_ready"); end
        n_vec++; if (axi_arvalid !== 1'b0) begin n_err++; $error("FAIL rst_arvalid"); end
        n_vec++; if (axi_awvalid !== 1'b0) begin n_err++; $error("FAIL rst_awvalid"); end
        n_vec++; if (axi_wvalid !== 1'b0) begin n_err++; $error("FAIL rst_wvalid"); end
        n_vec++; if (axi_rready !== 1'b0) begin n_err++; $error("FAIL rst_rready"); end
        n_vec++; if (axi_bready !== 1'b0) begin n_err++; $error("FAIL rst_bready"); end
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $error("FAIL rst_resp_valid"); end
        n_vec++; if (resp_rdata !== 32'h0) begin n_err++; $error("FAIL rst_resp_rdata"); end
        n_vec++; if (axi_wstrb !== 4'h0) begin n_err++; $error("FAIL rst_wstrb"); end
        n_vec++; if (axi_awaddr !== 32'h0) begin n_err++; $error("FAIL rst_awaddr"); end
        #2 rstn = 1'b1;

        do_req(1'b1, 2'd2, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0,
               32'h0000_1004, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0, 3);

        s_rdata = 32'h12F0_3456;
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_2002, 32'h0, 1'b0,
               32'h0000_2000, 32'h0, 4'h0, 32'hFFFF_FFF0, 1'b0, 3);
        do_req(1'b0, 2'd0, 1'b1, 32'h0000_2002, 32'h0, 1'b0,
               32'h0000_2000, 32'h0, 4'h0, 32'h0000_00F0, 1'b0, 3);

        s_rdata = 32'h8001_1234;
        do_req(1'b0, 2'd1, 1'b0, 32'h0000_6002, 32'h0, 1'b0,
               32'h0000_6000, 32'h0, 4'h0, 32'hFFFF_8001, 1'b0, 3);
        s_rdata = 32'h1234_9ABC;
        do_req(1'b0, 2'd1, 1'b1, 32'h0000_6000, 32'h0, 1'b0,
               32'h0000_6000, 32'h0, 4'h0, 32'h0000_9ABC, 1'b0, 3);

        do_req(1'b1, 2'd0, 1'b0, 32'h0000_7003, 32'h0000_005A, 1'b0,
               32'h0000_7000, 32'h5A00_0000, 4'b1000, 32'h0, 1'b0, 3);

        aw_dly = 3;
        s_aw = awv_cyc; s_w = wv_cyc; s_b = b_hs;
        do_req(1'b1, 2'd1, 1'b0, 32'h0000_3002, 32'h0000_ABCD, 1'b0,
               32'h0000_3000, 32'hABCD_0000, 4'b1100, 32'h0, 1'b0, 6);
        n_vec++; if (wv_cyc - s_w !== 1) begin n_err++; $error("FAIL wvalid_cycles: %0d", wv_cyc - s_w); end
        n_vec++; if (awv_cyc - s_aw !== 4) begin n_err++; $error("FAIL awvalid_cycles: %0d", awv_cyc - s_aw); end
        n_vec++; if (b_hs - s_b !== 1) begin n_err++; $error("FAIL b_handshakes: %0d", b_hs - s_b); end
        aw_dly = 0;

        s_ar = arv_cyc; s_aw = awv_cyc;
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_4001, 32'h0, 1'b1,
               32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1);
        do_req(1'b1, 2'd1, 1'b0, 32'h0000_4003, 32'h1111_2222, 1'b1,
               32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1);
        do_req(1'b0, 2'd3, 1'b0, 32'h0000_9000, 32'h0, 1'b1,
               32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1);
        n_vec++; if (arv_cyc - s_ar !== 0) begin n_err++; $error("FAIL misaligned_no_ar: %0d", arv_cyc - s_ar); end
        n_vec++; if (awv_cyc - s_aw !== 0) begin n_err++; $error("FAIL misaligned_no_aw: %0d", awv_cyc - s_aw); end

        s_rresp = 2'b10; s_rdata = 32'hCAFE_F00D;
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_8000, 32'h0, 1'b0,
               32'h0000_8000, 32'h0, 4'h0, 32'h0, 1'b1, 3);
        s_rresp = 2'b00;
        s_bresp = 2'b10;
        do_req(1'b1, 2'd2, 1'b0, 32'h0000_8004, 32'h0102_0304, 1'b0,
               32'h0000_8004, 32'h0102_0304, 4'b1111, 32'h0, 1'b1, 3);
        s_bresp = 2'b00;

        s_resp = resp_cnt;
        s_rdata = 32'h7654_3210;
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_A000, 32'h0, 1'b0,
               32'h0000_A000, 32'h0, 4'h0, 32'h7654_3210, 1'b0, 3);
        do_req(1'b1, 2'd1, 1'b0, 32'h0000_A000, 32'h0000_BEEF, 1'b0,
               32'h0000_A000, 32'h0000_BEEF, 4'b0011, 32'h0, 1'b0, 3);
        n_vec++; if (resp_cnt - s_resp !== 2) begin n_err++; $error("FAIL b2b_resp_count: %0d", resp_cnt - s_resp); end

        r_dly = 5;
        s_resp = resp_cnt;
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h0000_5000;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!axi_rready && k < 20);
        n_vec++; if (axi_rready !== 1'b1) begin n_err++; $error("FAIL reached_rd_data"); end
        #2 rstn = 1'b0;
        #1;
        n_vec++; if (axi_arvalid !== 1'b0) begin n_err++; $error("FAIL rst_mid_arvalid"); end
        n_vec++; if (axi_rready !== 1'b0) begin n_err++; $error("FAIL rst_mid_rready"); end
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $error("FAIL rst_mid_resp_valid"); end
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $error("FAIL rst_mid_req_ready"); end
        @(negedge clk);
        #3 rstn = 1'b1;
        r_dly = 0;
        n_vec++; if (resp_cnt - s_resp !== 0) begin n_err++; $error("FAIL rst_mid_no_resp: %0d", resp_cnt - s_resp); end
        s_rdata = 32'h0BAD_CAFE;
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0, 1'b0,
               32'h0000_5000, 32'h0, 4'h0, 32'h0BAD_CAFE, 1'b0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
